reg_bank_arbiter: RTL

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_bank_storage.sv | 39 +++
 rtl/reg_bank_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the arbitrated register bank.
package reg_bank_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 4;

    // Transaction FSM: sample/arbitrate, access the bank, report completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/reg_bank_storage.sv
// DEPTH x DATA_W register file with synchronous clear, one write port and
// one combinational read port.
//   clk       : clock
//   i_clr     : synchronous active-high clear of every word
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write data
//   i_raddr   : read address
//   o_rdata_c : combinational read data
module reg_bank_storage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Clear has priority over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a small register bank.
// Each granted request performs one read or write and ends with a one-cycle
// done pulse; a new request can be issued every 3 cycles.
//   clk            : clock
//   R              : synchronous active-high reset
//   req[1:0]       : per-requester request
//   we0/we1        : 1 = write, 0 = read
//   addr0/addr1    : bank address
//   wdata0/wdata1  : write data
//   gnt[1:0]       : one-hot grant, held from BUSY through DONE
//   done[1:0]      : completion pulse for the granted requester
//   rdata          : last read result, valid while done is high
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      R,
    input  logic [1:0]                req,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [$clog2(DEPTH)-1:0]  addr0,
    input  logic [$clog2(DEPTH)-1:0]  addr1,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic [DATA_W-1:0]         wdata1,
    output logic [1:0]                gnt,
    output logic [1:0]                done,
    output logic [DATA_W-1:0]         rdata
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_winner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_gnt;
    logic [1:0]          r_done;
    logic                w_winner;
    logic                w_bank_we;
    logic [DATA_W-1:0]   w_bank_rdata;

    // Winner select: single requester wins outright, contention alternates.
    always_comb begin
        w_winner = 1'b0;
        case (req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last_winner;
            default: w_winner = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req != 2'b00) w_next_state = BUSY;
            BUSY:    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch, grant/done outputs and read-data register.
    always_ff @(posedge clk) begin
        if (R) begin
            r_last_winner <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_gnt         <= 2'b00;
            r_done        <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 2'b00;
                    if (req != 2'b00) begin
                        r_last_winner <= w_winner;
                        r_we          <= w_winner ? we1    : we0;
                        r_addr        <= w_winner ? addr1  : addr0;
                        r_wdata       <= w_winner ? wdata1 : wdata0;
                        r_gnt         <= w_winner ? 2'b10  : 2'b01;
                    end else begin
                        r_gnt <= 2'b00;
                    end
                end
                BUSY: begin
                    if (!r_we) begin
                        r_rdata <= w_bank_rdata;
                    end
                    r_done <= r_gnt;
                end
                DONE: begin
                    r_gnt  <= 2'b00;
                    r_done <= 2'b00;
                end
                default: begin
                    r_gnt  <= 2'b00;
                    r_done <= 2'b00;
                end
            endcase
        end
    end

    assign w_bank_we = (r_state == BUSY) && r_we;

    reg_bank_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk       (clk),
        .i_clr     (R),
        .i_we      (w_bank_we),
        .i_waddr   (r_addr),
        .i_wdata   (r_wdata),
        .i_raddr   (r_addr),
        .o_rdata_c (w_bank_rdata)
    );

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign rdata = r_rdata;

endmodule
